// File: rtl/dmux_stream.sv
// 1:2^SEL_W stream demultiplexer with one holding register and optional per-packet route lock.
// Latency 1 cycle; s_ready = !full | m_ready[dest], so a stalled destination stalls the input.
module dmux_stream #(
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 3,
    parameter int PKT_MODE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       s_data,
    input  logic [SEL_W-1:0]        s_sel,
    input  logic                    s_last,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic [(1<<SEL_W)-1:0]   m_valid,
    input  logic [(1<<SEL_W)-1:0]   m_ready,
    output logic                    busy,
    output logic [15:0]             beat_cnt
);

    typedef enum logic {IDLE, OPEN} lock_state_t;

    lock_state_t       state, state_nxt;
    logic              full;
    logic [SEL_W-1:0]  dest;
    logic [SEL_W-1:0]  lock_sel, lock_sel_nxt;
    logic [SEL_W-1:0]  route;
    logic              accept;
    logic              deliver;

    // Refill is allowed in the same cycle the held beat leaves.
    assign deliver = full & m_ready[dest];
    assign s_ready = ~full | m_ready[dest];
    assign accept  = s_valid & s_ready;

    // OPEN is only reachable with PKT_MODE set, so per-beat mode always uses s_sel.
    assign route = (state == OPEN) ? lock_sel : s_sel;
    assign busy  = (state == OPEN);

    always_comb begin
        state_nxt    = state;
        lock_sel_nxt = lock_sel;
        if (PKT_MODE != 0 && accept) begin
            case (state)
                IDLE: begin
                    if (!s_last) begin
                        state_nxt    = OPEN;
                        lock_sel_nxt = s_sel;
                    end
                end
                OPEN: begin
                    if (s_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= '0;
            full     <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            dest     <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_sel <= lock_sel_nxt;
            if (accept) begin
                m_data <= s_data;
                m_last <= s_last;
                dest   <= route;
                full   <= 1'b1;
            end else if (deliver) begin
                full <= 1'b0;
            end
            if (deliver) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        m_valid = '0;
        if (full) begin
            m_valid[dest] = 1'b1;
        end
    end

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of the pending beat and packet lock.
module tb_dmux_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic [2:0] s_sel = '0;
    logic       s_last = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] m_ready = 8'hFF;

    logic        s_ready, m_last, busy;
    logic [7:0]  m_data, m_valid;
    logic [15:0] beat_cnt;
    logic        pb_s_ready, pb_m_last, pb_busy;
    logic [7:0]  pb_m_data, pb_m_valid;
    logic [15:0] pb_beat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmux_stream #(.DATA_W(8), .SEL_W(3), .PKT_MODE(1)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .beat_cnt(beat_cnt)
    );

    dmux_stream #(.DATA_W(8), .SEL_W(3), .PKT_MODE(0)) dut_pb (
        .clk(clk), .rst(rst), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
        .s_valid(s_valid), .s_ready(pb_s_ready), .m_data(pb_m_data), .m_last(pb_m_last),
        .m_valid(pb_m_valid), .m_ready(m_ready), .busy(pb_busy), .beat_cnt(pb_beat_cnt)
    );

    // Reference model: at most one pending beat, the open-packet channel, a delivery count.
    typedef struct {
        logic [7:0] d;
        logic       l;
        int         ch;
    } beat_t;

    beat_t pend[$];
    bit    pkt_open = 0;
    int    lock_ch  = 0;
    int    cnt      = 0;
    bit    model_ok = 0;

    always @(posedge clk) begin
        bit dlv, acc;
        int ch;
        if (rst) begin
            pend.delete();
            pkt_open = 0;
            lock_ch  = 0;
            cnt      = 0;
            model_ok = 1;
        end else if (model_ok) begin
            dlv = (pend.size() != 0) && m_ready[pend[0].ch];
            acc = s_valid && ((pend.size() == 0) || dlv);
            ch  = pkt_open ? lock_ch : int'(s_sel);
            if (dlv) begin
                void'(pend.pop_front());
                cnt = (cnt + 1) % 65536;
            end
            if (acc) begin
                pend.push_back('{s_data, s_last, ch});
                if (!pkt_open && !s_last) begin
                    pkt_open = 1;
                    lock_ch  = int'(s_sel);
                end else if (pkt_open && s_last) begin
                    pkt_open = 0;
                end
            end
        end
    end

    int ch_seen [8];
    bit hs_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic [7:0] exp_mv;
        bit         exp_rdy;
        hs_seen = s_valid && s_ready;
        for (int c = 0; c < 8; c++) begin
            if (m_valid[c] && m_ready[c]) ch_seen[c]++;
        end
        if (!model_ok) return;
        exp_mv  = (pend.size() != 0) ? (8'h01 << pend[0].ch) : 8'h00;
        exp_rdy = (pend.size() == 0) || m_ready[pend[0].ch];
        chk("m_valid", {24'h0, m_valid}, {24'h0, exp_mv});
        if (pend.size() != 0) begin
            chk("m_data", {24'h0, m_data}, {24'h0, pend[0].d});
            chk("m_last", {31'h0, m_last}, {31'h0, pend[0].l});
        end
        chk("s_ready", {31'h0, s_ready}, {31'h0, exp_rdy});
        chk("busy", {31'h0, busy}, {31'h0, pkt_open});
        chk("beat_cnt", {16'h0, beat_cnt}, cnt);
        chk("pb_busy", {31'h0, pb_busy}, 32'h0);
    endtask

    // Model check mid-cycle, then return 1 time unit after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 8'hFF;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] sel, input logic l);
        s_data  = d;
        s_sel   = sel;
        s_last  = l;
        s_valid = 1'b1;
    endtask

    logic [2:0] pk_sel [3];
    logic [7:0] pb_exp [3];
    int         base [8];

    initial begin
        pk_sel = '{3'd3, 3'd6, 3'd1};
        pb_exp = '{8'h08, 8'h40, 8'h02};

        do_reset();
        chk("rst_m_valid", {24'h0, m_valid}, 32'h0);
        chk("rst_s_ready", {31'h0, s_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_beat_cnt", {16'h0, beat_cnt}, 32'h0);
        chk("rst_m_data", {24'h0, m_data}, 32'h0);
        chk("rst_m_last", {31'h0, m_last}, 32'h0);

        drive(8'hA5, 3'd5, 1'b1);
        cycle();
        s_valid = 1'b0;
        chk("single_m_valid", {24'h0, m_valid}, 32'h20);
        chk("single_m_data", {24'h0, m_data}, 32'hA5);
        chk("single_m_last", {31'h0, m_last}, 32'h1);
        cycle();
        chk("single_drain", {24'h0, m_valid}, 32'h0);
        chk("single_cnt", {16'h0, beat_cnt}, 32'h1);

        do_reset();
        m_ready = 8'h00;
        drive(8'h11, 3'd2, 1'b1);
        cycle();
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_m_valid", {24'h0, m_valid}, 32'h04);
            chk("bp_s_ready", {31'h0, s_ready}, 32'h0);
            chk("bp_m_data", {24'h0, m_data}, 32'h11);
            cycle();
        end
        m_ready = 8'h04;
        drive(8'h22, 3'd2, 1'b1);
        cycle();
        s_valid = 1'b0;
        chk("bp_refill_valid", {24'h0, m_valid}, 32'h04);
        chk("bp_refill_data", {24'h0, m_data}, 32'h22);
        chk("bp_cnt1", {16'h0, beat_cnt}, 32'h1);
        cycle();
        chk("bp_drain", {24'h0, m_valid}, 32'h0);
        chk("bp_cnt2", {16'h0, beat_cnt}, 32'h2);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(8'(i + 1), pk_sel[i], (i == 2));
            cycle();
            chk($sformatf("pkt_m_valid%0d", i), {24'h0, m_valid}, 32'h08);
            chk($sformatf("pkt_busy%0d", i), {31'h0, busy}, (i < 2) ? 32'h1 : 32'h0);
            chk($sformatf("pb_m_valid%0d", i), {24'h0, pb_m_valid}, {24'h0, pb_exp[i]});
            chk($sformatf("pb_busy%0d", i), {31'h0, pb_busy}, 32'h0);
        end
        drive(8'h04, 3'd6, 1'b1);
        cycle();
        s_valid = 1'b0;
        chk("pkt_next_valid", {24'h0, m_valid}, 32'h40);
        chk("pkt_next_busy", {31'h0, busy}, 32'h0);
        cycle();

        do_reset();
        for (int c = 0; c < 8; c++) base[c] = ch_seen[c];
        for (int i = 0; i < 256; i++) begin
            drive(8'(i), 3'(i % 8), 1'b1);
            cycle();
            chk("tp_s_ready", {31'h0, s_ready}, 32'h1);
        end
        s_valid = 1'b0;
        cycle();
        cycle();
        chk("tp_beat_cnt", {16'h0, beat_cnt}, 32'd256);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("tp_ch%0d_beats", c), ch_seen[c] - base[c], 32'd32);
        end

        do_reset();
        m_ready = 8'h00;
        drive(8'h44, 3'd4, 1'b0);
        cycle();
        s_valid = 1'b0;
        chk("mid_busy", {31'h0, busy}, 32'h1);
        chk("mid_m_valid", {24'h0, m_valid}, 32'h10);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", {24'h0, m_valid}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_cnt", {16'h0, beat_cnt}, 32'h0);
        chk("mid_rst_s_ready", {31'h0, s_ready}, 32'h1);
        m_ready = 8'hFF;
        drive(8'h55, 3'd2, 1'b1);
        cycle();
        s_valid = 1'b0;
        chk("mid_after_valid", {24'h0, m_valid}, 32'h04);
        chk("mid_after_busy", {31'h0, busy}, 32'h0);

        for (int n = 0; n < 4000; n++) begin
            cycle();
            if (rst || !s_valid || hs_seen) begin
                s_valid = ($urandom_range(3) != 0);
                s_data  = 8'($urandom);
                s_sel   = 3'($urandom);
                s_last  = ($urandom_range(2) == 0);
            end
            m_ready = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom);
            rst     = ($urandom_range(199) == 0);
        end
        rst = 1'b0;
        s_valid = 1'b0;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux_stream.md
# dmux_stream

Parametrised 1:2^SEL_W stream demultiplexer with one registered output stage and a valid/ready handshake on both sides. It is the sequential successor of the structural 1:8 demultiplexer tree: it routes an 8-bit-class data word to one of N channels, with back-pressure, and optionally holds the route for a whole packet. It sits between a single producer (UART RX framer, pattern generator) and several consumers (LED/display drivers, per-channel FIFOs) on the board-level datapath.

## Interface
- DATA_W, default 8: data word width, ≥1.
- SEL_W, default 3: select width; channel count N = 2^SEL_W, SEL_W ≥ 1.
- PKT_MODE, default 1: 1 = route latched at first beat of a packet and held until the `last` beat; 0 = every beat routed by its own `s_sel`.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  input word.
- s_sel  in  SEL_W  destination channel for this beat.
- s_last  in  1  marks final beat of a packet.
- s_valid  in  1  input beat present.
- s_ready  out  1  block accepts a beat this cycle.
- m_data  out  DATA_W  output word, common to all channels.
- m_last  out  1  `last` flag of the held beat, common to all channels.
- m_valid  out  N  one-hot valid; bit i = beat held for channel i.
- m_ready  in  N  per-channel ready.
- busy  out  1  in PKT_MODE: a packet is open (route locked); 0 otherwise.
- beat_cnt  out  16  delivered-beat counter, wraps 0xFFFF→0.

## Operation
- Single holding register: `full`, `data`, `last`, `dest` (SEL_W bits). Lock state: `in_pkt`, `lock_sel`.
- Accept = s_valid & s_ready. Deliver = full & m_ready[dest].
- s_ready = !full | m_ready[dest] (pass-through refill; combinational from m_ready, no combinational path from s_valid).
- Route used on accept: PKT_MODE & in_pkt ? lock_sel : s_sel. `s_sel` ignored on non-first beats of a packet.
- On accept: data←s_data, last←s_last, dest←route, full←1.
- On deliver without accept: full←0. Deliver and accept in the same cycle: register reloaded, full stays 1.
- m_valid = full ? (1 << dest) : 0; never more than one bit set. m_data/m_last driven from the register regardless of full.
- Lock FSM (PKT_MODE=1), two states:
  - IDLE (in_pkt=0): accept with s_last=0 → OPEN, lock_sel←s_sel; accept with s_last=1 → stay IDLE (single-beat packet).
  - OPEN (in_pkt=1): accept with s_last=1 → IDLE; otherwise stay.
  - PKT_MODE=0: in_pkt held 0.
- busy = in_pkt.
- beat_cnt increments by 1 on each deliver; modulo 2^16.
- Bubble-free: sustained 1 beat/cycle when destination keeps m_ready high.
- Channels whose m_ready is high but are not `dest` have no effect.

## Timing
- Latency: beat accepted at edge k appears on m_valid/m_data after edge k (visible during cycle k+1).
- Reset (rst high at an edge) forces next cycle: full=0, m_valid=0, m_data=0, m_last=0, dest=0, in_pkt=0, lock_sel=0, busy=0, beat_cnt=0, s_ready=1.
- Reset mid-packet or with a held beat: beat discarded, lock released, no delivery counted; rst has priority over accept/deliver in the same cycle.
- Output stable: while full & !m_ready[dest], data/last/dest unchanged.
- Input must hold s_data/s_sel/s_last stable while s_valid & !s_ready (producer rule; not checked).
- busy changes on the same edge as the accept of the first/last beat.

## Test plan
- Reset then single beat: s_data=0xA5, s_sel=5, s_last=1, m_ready=0xFF → next cycle m_valid=0x20, m_data=0xA5, m_last=1; following cycle m_valid=0, beat_cnt=1.
- Back-pressure: send 0x11 to ch 2 with m_ready=0 for 4 cycles → m_valid=0x04 held, s_ready=0 throughout, m_data=0x11; raise m_ready[2] with next beat 0x22 valid → both delivered back-to-back, beat_cnt=2.
- Packet lock (PKT_MODE=1): 3 beats 0x01,0x02,0x03 with s_sel=3,6,1 and last on beat 3 → all three on m_valid=0x08; busy=1 after beat 1, 0 after beat 3; next packet with s_sel=6 goes to 0x40.
- Per-beat mode (PKT_MODE=0): same stimulus → m_valid sequence 0x08,0x40,0x02; busy stays 0.
- Full throughput: 256 beats round-robin s_sel=0..7, all m_ready=1, s_valid constant → s_ready never drops, beat_cnt=256, each channel sees 32 beats in order.
- Reset mid-packet: open packet on ch 4, held beat stalled, assert rst one cycle → m_valid=0, busy=0, beat_cnt=0; next beat with s_sel=2 routes to 0x04.
